// File: rtl/cmd_bus_if.sv
// Requester handshake plus shared 4-bit cmd/adr/data bus between the arbiter and its peers.
// The arbiter drives the bus through the master modport; requesters and observers use slave.
interface cmd_bus_if #(
    parameter int NUM_REQ = 4
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_cmd;
    logic [4*NUM_REQ-1:0] req_adr;
    logic [4*NUM_REQ-1:0] req_data;
    logic [3:0]           bus_cmd;
    logic [3:0]           bus_adr;
    logic [3:0]           bus_data;
    logic [OW-1:0]        bus_owner;
    logic                 bus_busy;

    modport master (
        input  req_valid, req_last, req_cmd, req_adr, req_data,
        output req_ready, bus_cmd, bus_adr, bus_data, bus_owner, bus_busy
    );

    modport slave (
        output req_valid, req_last, req_cmd, req_adr, req_data,
        input  req_ready, bus_cmd, bus_adr, bus_data, bus_owner, bus_busy
    );
endinterface

// File: rtl/cmd_bus_arbiter.sv
// Round-robin burst arbiter: one requester owns the registered cmd/adr/data bus per grant,
// bursts end on last, on MAX_BURST beats, or when the owner stops presenting a beat.
module cmd_bus_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic      clk,
    input  logic      rst,
    cmd_bus_if.master bus
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_reg, state_next;
    logic [OW-1:0] ptr_reg, ptr_next;
    logic [OW-1:0] owner_reg, owner_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [3:0]    cmd_reg, cmd_next;
    logic [3:0]    adr_reg, adr_next;
    logic [3:0]    data_reg, data_next;

    logic [3:0]    cmd_arr  [NUM_REQ];
    logic [3:0]    adr_arr  [NUM_REQ];
    logic [3:0]    data_arr [NUM_REQ];
    logic [OW-1:0] winner;
    logic          found;
    logic [OW:0]   sum;
    logic          owner_valid;
    logic          owner_last;
    logic          beat_end;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign cmd_arr[gi]       = bus.req_cmd[4*gi +: 4];
            assign adr_arr[gi]       = bus.req_adr[4*gi +: 4];
            assign data_arr[gi]      = bus.req_data[4*gi +: 4];
            assign bus.req_ready[gi] = (state_reg == GRANT) && (owner_reg == OW'(gi));
        end
    endgenerate

    // Lowest rotation offset from ptr wins, so the search walks ptr, ptr+1, ... with wrap.
    always_comb begin
        found  = 1'b0;
        winner = ptr_reg;
        sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_reg} + (OW+1)'(k);
            if (sum >= (OW+1)'(NUM_REQ)) begin
                sum = sum - (OW+1)'(NUM_REQ);
            end
            if (!found && bus.req_valid[sum[OW-1:0]]) begin
                found  = 1'b1;
                winner = sum[OW-1:0];
            end
        end
    end

    assign owner_valid = bus.req_valid[owner_reg];
    assign owner_last  = bus.req_last[owner_reg];

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        cnt_next   = cnt_reg;
        cmd_next   = 4'd0;
        adr_next   = 4'd0;
        data_next  = 4'd0;
        beat_end   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    owner_next = winner;
                    cnt_next   = 4'd0;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (owner_valid) begin
                    cmd_next  = cmd_arr[owner_reg];
                    adr_next  = adr_arr[owner_reg];
                    data_next = data_arr[owner_reg];
                    beat_end  = owner_last || (cnt_reg == 4'(MAX_BURST-1));
                    // Counter saturates at MAX_BURST-1 on the closing beat.
                    if (!beat_end) begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end else begin
                    beat_end = 1'b1;
                end
                if (beat_end) begin
                    state_next = IDLE;
                    ptr_next   = (owner_reg == OW'(NUM_REQ-1)) ? '0 : owner_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            owner_reg <= '0;
            cnt_reg   <= 4'd0;
            cmd_reg   <= 4'd0;
            adr_reg   <= 4'd0;
            data_reg  <= 4'd0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            cnt_reg   <= cnt_next;
            cmd_reg   <= cmd_next;
            adr_reg   <= adr_next;
            data_reg  <= data_next;
        end
    end

    assign bus.bus_cmd   = cmd_reg;
    assign bus.bus_adr   = adr_reg;
    assign bus.bus_data  = data_reg;
    assign bus.bus_owner = owner_reg;
    assign bus.bus_busy  = (state_reg == GRANT);
endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// Bench for cmd_bus_arbiter: hand-written vector table, directed corner sequences,
// then randomized requesters checked against a transaction-level arbitration model.
module tb_cmd_bus_arbiter;
    localparam int N  = 4;
    localparam int MB = 4;

    logic clk;
    logic rst;

    cmd_bus_if #(.NUM_REQ(N)) bif ();

    cmd_bus_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who holds the bus, beats taken this burst, next priority, what the bus shows.
    int         m_busy, m_owner, m_beats, m_ptr;
    logic [3:0] m_cmd, m_adr, m_data;
    int         beats [N];
    logic [N-1:0] acc;

    typedef struct {
        logic        rst;
        logic [3:0]  valid, last;
        logic [15:0] cmd, adr, data;
        logic [3:0]  e_ready, e_cmd, e_adr, e_data;
        logic [1:0]  e_owner;
        logic        e_busy;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic [15:0] c,
                                logic [15:0] a, logic [15:0] d, logic [3:0] er, logic [3:0] ec,
                                logic [3:0] ea, logic [3:0] ed, logic [1:0] eo, logic eb);
        vec_t x;
        x.rst = r; x.valid = v; x.last = l; x.cmd = c; x.adr = a; x.data = d;
        x.e_ready = er; x.e_cmd = ec; x.e_adr = ea; x.e_data = ed; x.e_owner = eo; x.e_busy = eb;
        return x;
    endfunction

    function automatic logic [31:0] pack(logic [3:0] r, logic [3:0] c, logic [3:0] a,
                                         logic [3:0] d, logic [1:0] o, logic b);
        return {13'd0, r, c, a, d, o, b};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_out();
        return pack(bif.req_ready, bif.bus_cmd, bif.bus_adr, bif.bus_data, bif.bus_owner, bif.bus_busy);
    endfunction

    function automatic logic [31:0] model_out();
        logic [3:0] r;
        r = m_busy != 0 ? 4'(1 << m_owner) : 4'd0;
        return pack(r, m_cmd, m_adr, m_data, 2'(m_owner), 1'(m_busy));
    endfunction

    task automatic model_update();
        logic [N-1:0] v;
        logic [N-1:0] l;
        v = bif.req_valid;
        l = bif.req_last;
        m_cmd = 0; m_adr = 0; m_data = 0;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
        end else if (m_busy == 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_busy == 0 && v[(m_ptr + k) % N]) begin
                    m_busy  = 1;
                    m_owner = (m_ptr + k) % N;
                    m_beats = 0;
                end
            end
        end else if (v[m_owner]) begin
            beats[m_owner]++;
            m_cmd  = bif.req_cmd[4*m_owner +: 4];
            m_adr  = bif.req_adr[4*m_owner +: 4];
            m_data = bif.req_data[4*m_owner +: 4];
            m_beats++;
            if (l[m_owner] || m_beats == MB) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % N;
            end
        end else begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % N;
        end
    endtask

    task automatic step();
        acc = bif.req_valid & bif.req_ready;
        model_update();
        for (int i = 0; i < N; i++) begin
            if (acc[i] && !rst)
                $display("beat req%0d cmd=%h adr=%h data=%h", i, bif.req_cmd[4*i +: 4],
                         bif.req_adr[4*i +: 4], bif.req_data[4*i +: 4]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bif.req_valid = '0; bif.req_last = '0;
        bif.req_cmd = '0; bif.req_adr = '0; bif.req_data = '0;
        step();
        check("reset_state", dut_out(), 32'd0);
        rst = 1'b0;
    endtask

    logic [3:0] seq [12];
    logic [3:0] exp_seq [6];
    int ph [N];
    int bmax, bmin;

    initial begin
        rst = 1'b1;
        bif.req_valid = '0; bif.req_last = '0;
        bif.req_cmd = '0; bif.req_adr = '0; bif.req_data = '0;
        m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
        m_cmd = 0; m_adr = 0; m_data = 0;
        for (int i = 0; i < N; i++) beats[i] = 0;

        // Single 3-beat burst from req 2, pointer effect, simultaneous request, reset.
        vecs[0] = mk(1, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 0);
        vecs[1] = mk(0, 4'h4, 4'h0, 16'h0100, 16'h0500, 16'h0900, 4'h4, 4'h0, 4'h0, 4'h0, 2'd2, 1);
        vecs[2] = mk(0, 4'h4, 4'h0, 16'h0100, 16'h0500, 16'h0900, 4'h4, 4'h1, 4'h5, 4'h9, 2'd2, 1);
        vecs[3] = mk(0, 4'h4, 4'h0, 16'h0200, 16'h0600, 16'h0A00, 4'h4, 4'h2, 4'h6, 4'hA, 2'd2, 1);
        vecs[4] = mk(0, 4'h4, 4'h4, 16'h0300, 16'h0700, 16'h0B00, 4'h0, 4'h3, 4'h7, 4'hB, 2'd2, 0);
        vecs[5] = mk(0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 4'h0, 2'd2, 0);
        vecs[6] = mk(0, 4'hF, 4'hF, 16'hC000, 16'h3000, 16'h5000, 4'h8, 4'h0, 4'h0, 4'h0, 2'd3, 1);
        vecs[7] = mk(0, 4'hF, 4'hF, 16'hC000, 16'h3000, 16'h5000, 4'h0, 4'hC, 4'h3, 4'h5, 2'd3, 0);
        vecs[8] = mk(0, 4'hF, 4'hF, 16'hC000, 16'h3000, 16'h5000, 4'h1, 4'h0, 4'h0, 4'h0, 2'd0, 1);
        vecs[9] = mk(1, 4'hF, 4'hF, 16'hC000, 16'h3000, 16'h5000, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 0);

        for (int r = 0; r < 10; r++) begin
            rst = vecs[r].rst;
            bif.req_valid = vecs[r].valid; bif.req_last = vecs[r].last;
            bif.req_cmd = vecs[r].cmd; bif.req_adr = vecs[r].adr; bif.req_data = vecs[r].data;
            step();
            check($sformatf("vec%0d", r), dut_out(),
                  pack(vecs[r].e_ready, vecs[r].e_cmd, vecs[r].e_adr, vecs[r].e_data,
                       vecs[r].e_owner, vecs[r].e_busy));
            if (r == 5) check("ptr_after_burst", 32'(dut.ptr_reg), 32'd3);
        end

        // Contention: req 0 and 1 always valid with one-beat bursts.
        do_reset();
        bif.req_valid = 4'b0011; bif.req_last = 4'b0011; bif.req_cmd = 16'h0084;
        for (int c = 0; c < 12; c++) begin
            step();
            check("contention_model", dut_out(), model_out());
            seq[c] = bif.bus_cmd;
        end
        exp_seq[0] = 4'd0; exp_seq[1] = 4'd4; exp_seq[2] = 4'd0;
        exp_seq[3] = 4'd8; exp_seq[4] = 4'd0; exp_seq[5] = 4'd4;
        for (int c = 0; c < 6; c++) check($sformatf("contention_cmd%0d", c), 32'(seq[c]), 32'(exp_seq[c]));

        // MAX_BURST cutoff: req 3 never asserts last.
        do_reset();
        bif.req_valid = 4'b1000; bif.req_cmd = 16'h7000;
        for (int i = 0; i < N; i++) beats[i] = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("cutoff_model", dut_out(), model_out());
        end
        check("cutoff_beats", 32'(beats[3]), 32'd4);
        check("cutoff_idle", 32'(bif.bus_busy), 32'd0);
        check("cutoff_ptr", 32'(dut.ptr_reg), 32'd0);
        step();
        check("cutoff_regrant", {29'd0, bif.bus_busy, bif.bus_owner}, {29'd0, 1'b1, 2'd3});

        // Valid drop after one beat from req 1.
        do_reset();
        bif.req_valid = 4'b0010; bif.req_cmd = 16'h0050;
        step(); check("drop_model", dut_out(), model_out());
        step(); check("drop_model", dut_out(), model_out());
        bif.req_valid = 4'b0000;
        step(); check("drop_model", dut_out(), model_out());
        check("drop_cnt", 32'(dut.cnt_reg), 32'd1);
        check("drop_cmd", 32'(bif.bus_cmd), 32'd0);
        check("drop_ptr", 32'(dut.ptr_reg), 32'd2);

        // Reset landing on the second beat of a burst from req 2.
        do_reset();
        bif.req_valid = 4'b0100; bif.req_cmd = 16'h0900;
        step(); step();
        rst = 1'b1;
        step();
        check("midrst_outputs", dut_out(), 32'd0);
        check("midrst_ptr", 32'(dut.ptr_reg), 32'd0);
        rst = 1'b0;
        bif.req_valid = 4'b0101; bif.req_cmd = 16'h0902;
        step();
        check("midrst_regrant", {29'd0, bif.bus_busy, bif.bus_owner}, {29'd0, 1'b1, 2'd0});

        // Fairness sweep: everyone valid, two-beat bursts.
        do_reset();
        for (int i = 0; i < N; i++) begin beats[i] = 0; ph[i] = 0; end
        bif.req_valid = 4'b1111; bif.req_last = 4'b0000; bif.req_cmd = 16'h4321;
        for (int c = 0; c < 40; c++) begin
            step();
            check("fair_model", dut_out(), model_out());
            for (int i = 0; i < N; i++) if (acc[i]) ph[i] = 1 - ph[i];
            for (int i = 0; i < N; i++) bif.req_last[i] = 1'(ph[i]);
        end
        bmax = beats[0]; bmin = beats[0];
        for (int i = 1; i < N; i++) begin
            if (beats[i] > bmax) bmax = beats[i];
            if (beats[i] < bmin) bmin = beats[i];
        end
        check("fair_spread_ok", 32'((bmax - bmin) <= 2), 32'd1);

        // Randomized requesters that hold beats until accepted.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            step();
            check("random_model", dut_out(), model_out());
            for (int i = 0; i < N; i++) begin
                if ((!bif.req_valid[i] && $urandom_range(0, 2) == 0) ||
                    (acc[i] && $urandom_range(0, 1) == 0)) begin
                    bif.req_valid[i] = 1'b1;
                    bif.req_last[i]  = ($urandom_range(0, 2) == 0);
                    bif.req_cmd[4*i +: 4]  = 4'($urandom);
                    bif.req_adr[4*i +: 4]  = 4'($urandom);
                    bif.req_data[4*i +: 4] = 4'($urandom);
                end else if (acc[i]) begin
                    bif.req_valid[i] = 1'b0;
                end
            end
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
